// File: rtl/keypad_pkg.sv
// Shared keypad types and constants for the key-entry path.
package keypad_pkg;

  localparam logic [3:0] KEY_MAX_DIGIT = 4'd9;
  localparam logic [3:0] KEY_STAR      = 4'd10;
  localparam logic [3:0] KEY_HASH      = 4'd11;

  typedef logic [3:0] bcd_t;

  typedef enum logic {IDLE, CONV} ctrl_state_e;
  typedef enum logic {HELD, ARMED} press_state_e;

  // One decimal accumulation step; acc*10 is built from shifts so no multiplier is inferred.
  function automatic logic [9:0] mac10(input logic [9:0] acc, input bcd_t d);
    return (acc << 3) + (acc << 1) + {6'd0, d};
  endfunction

endpackage

// File: rtl/key_press_edge.sv
// Turns a level-valid key stream into one press event per physical press.
//   state | meaning
//   HELD  | waiting for RELEASE_CYCLES consecutive low cycles
//   ARMED | next valid cycle emits a press
module key_press_edge
  import keypad_pkg::*;
#(
  parameter int unsigned RELEASE_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       press,
  output logic [3:0] press_code
);

  localparam logic [7:0] REL_LOAD = 8'(RELEASE_CYCLES);

  press_state_e state_q, state_d;
  logic [7:0]   rel_cnt_q, rel_cnt_d;

  // Reset lands in HELD so a key held through reset must be released first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= HELD;
      rel_cnt_q <= REL_LOAD;
    end else begin
      state_q   <= state_d;
      rel_cnt_q <= rel_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rel_cnt_d  = rel_cnt_q;
    press      = 1'b0;
    press_code = key_code;
    case (state_q)
      ARMED: begin
        if (key_valid) begin
          press     = 1'b1;
          state_d   = HELD;
          rel_cnt_d = REL_LOAD;
        end
      end
      HELD: begin
        if (key_valid) begin
          rel_cnt_d = REL_LOAD;
        end else if (rel_cnt_q == 8'd1) begin
          state_d   = ARMED;
          rel_cnt_d = REL_LOAD;
        end else begin
          rel_cnt_d = rel_cnt_q - 8'd1;
        end
      end
      default: state_d = HELD;
    endcase
  end

endmodule

// File: rtl/bcd_entry_ctrl.sv
// 3-digit BCD key-entry register with iterative BCD-to-binary commit on '#'.
//   state | meaning
//   IDLE  | accepting digit / '*' / '#' events
//   CONV  | three accumulation steps digit2, digit1, digit0
module bcd_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned RELEASE_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [1:0] entry_count,
  output logic       busy,
  output logic [9:0] value,
  output logic       value_valid
);

  logic       press;
  logic [3:0] press_code;

  key_press_edge #(.RELEASE_CYCLES(RELEASE_CYCLES)) u_press (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .press      (press),
    .press_code (press_code)
  );

  ctrl_state_e state_q, state_d;
  bcd_t        dig0_q, dig0_d, dig1_q, dig1_d, dig2_q, dig2_d;
  logic [1:0]  count_q, count_d;
  logic        fresh_q, fresh_d;
  logic [9:0]  acc_q, acc_d;
  logic [1:0]  step_q, step_d;
  logic [9:0]  value_q, value_d;
  logic        vv_q, vv_d;
  bcd_t        cur_digit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dig0_q  <= '0;
      dig1_q  <= '0;
      dig2_q  <= '0;
      count_q <= '0;
      fresh_q <= 1'b0;
      acc_q   <= '0;
      step_q  <= '0;
      value_q <= '0;
      vv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dig0_q  <= dig0_d;
      dig1_q  <= dig1_d;
      dig2_q  <= dig2_d;
      count_q <= count_d;
      fresh_q <= fresh_d;
      acc_q   <= acc_d;
      step_q  <= step_d;
      value_q <= value_d;
      vv_q    <= vv_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dig0_d    = dig0_q;
    dig1_d    = dig1_q;
    dig2_d    = dig2_q;
    count_d   = count_q;
    fresh_d   = fresh_q;
    acc_d     = acc_q;
    step_d    = step_q;
    value_d   = value_q;
    vv_d      = 1'b0;
    cur_digit = dig0_q;
    case (state_q)
      IDLE: begin
        if (press) begin
          if (press_code <= KEY_MAX_DIGIT) begin
            // First digit after a commit starts a new entry rather than shifting.
            if (fresh_q) begin
              dig2_d  = '0;
              dig1_d  = '0;
              dig0_d  = press_code;
              count_d = 2'd1;
              fresh_d = 1'b0;
            end else if (count_q != 2'd3) begin
              dig2_d  = dig1_q;
              dig1_d  = dig0_q;
              dig0_d  = press_code;
              count_d = count_q + 2'd1;
            end
          end else if (press_code == KEY_STAR) begin
            dig2_d  = '0;
            dig1_d  = '0;
            dig0_d  = '0;
            count_d = '0;
            fresh_d = 1'b0;
            value_d = '0;
          end else if (press_code == KEY_HASH && count_q != 2'd0) begin
            state_d = CONV;
            acc_d   = '0;
            step_d  = '0;
          end
        end
      end
      CONV: begin
        case (step_q)
          2'd0:    cur_digit = dig2_q;
          2'd1:    cur_digit = dig1_q;
          default: cur_digit = dig0_q;
        endcase
        acc_d  = mac10(acc_q, cur_digit);
        step_d = step_q + 2'd1;
        if (step_q == 2'd2) begin
          state_d = IDLE;
          value_d = acc_d;
          vv_d    = 1'b1;
          count_d = '0;
          fresh_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign digit0      = dig0_q;
  assign digit1      = dig1_q;
  assign digit2      = dig2_q;
  assign entry_count = count_q;
  assign busy        = (state_q == CONV);
  assign value       = value_q;
  assign value_valid = vv_q;

endmodule
